mem_arbiter: RTL and testbench

Two-port memory arbiter that shares the processor's single memory port (address, dataToMemory, writeEnable, dataFromMemory) between two requesters: port 0 (the dut datapath) and port 1 (the test/loader side). It accepts one transaction at a time, drives the memory port for one issue cycle, and returns an acknowledge with read data the following cycle. When both ports are requesting, it picks between them round-robin.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_pick2.sv | 36 +++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Transaction phase: waiting, driving the memory port, acknowledging.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    // Requester index: 0 = datapath, 1 = test/loader side.
    typedef logic port_idx_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker. On a tie the port that was not
// granted last time wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] eligible,
    input  port_idx_t  last,
    output logic       grant_valid,
    output port_idx_t  grant_idx
);

    // Choose the single eligible port, or alternate away from 'last' on a tie.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        case (eligible)
            2'b01: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b0;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b1;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_idx   = ~last;
            end
            default: begin
                grant_valid = 1'b0;
                grant_idx   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between two requesters. One transaction at a time:
// an ISSUE cycle drives the memory port, the following RESP cycle returns the
// ack and read data. All outputs decode from registered state, so there is no
// combinational path from any req input to any output.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dataToMemory,
    output logic              writeEnable,
    input  logic [DATA_W-1:0] dataFromMemory
);

    arb_state_t        state_r, state_s;
    port_idx_t         owner_r, owner_s;
    port_idx_t         last_r, last_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;

    logic [1:0]        eligible_s;
    logic              grant_valid_s;
    port_idx_t         grant_idx_s;

    // Requesting ports, excluding the one being acknowledged this cycle.
    always_comb begin
        eligible_s = {req1, req0};
        if (state_r == RESP) begin
            eligible_s[owner_r] = 1'b0;
        end else begin
            eligible_s = {req1, req0};
        end
    end

    rr_pick2 u_pick (
        .eligible    (eligible_s),
        .last        (last_r),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Next-state logic: arbitrate in IDLE/RESP, latch the winner's request.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        last_s  = last_r;
        we_s    = we_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        case (state_r)
            IDLE, RESP: begin
                if (grant_valid_s) begin
                    state_s = ISSUE;
                    owner_s = grant_idx_s;
                    last_s  = grant_idx_s;
                    if (grant_idx_s) begin
                        we_s    = we1;
                        addr_s  = addr1;
                        wdata_s = wdata1;
                    end else begin
                        we_s    = we0;
                        addr_s  = addr0;
                        wdata_s = wdata0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = RESP;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, ownership and latched-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            owner_r <= 1'b0;
            last_r  <= 1'b1;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            last_r  <= last_s;
            we_r    <= we_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
        end
    end

    // Output decode: memory port only in ISSUE, ack/rdata only in RESP.
    always_comb begin
        ack0         = 1'b0;
        ack1         = 1'b0;
        rdata0       = {DATA_W{1'b0}};
        rdata1       = {DATA_W{1'b0}};
        address      = {ADDR_W{1'b0}};
        dataToMemory = {DATA_W{1'b0}};
        writeEnable  = 1'b0;
        case (state_r)
            ISSUE: begin
                address     = addr_r;
                writeEnable = we_r;
                if (we_r) begin
                    dataToMemory = wdata_r;
                end else begin
                    dataToMemory = {DATA_W{1'b0}};
                end
            end
            RESP: begin
                if (owner_r) begin
                    ack1   = 1'b1;
                    rdata1 = we_r ? {DATA_W{1'b0}} : dataFromMemory;
                end else begin
                    ack0   = 1'b1;
                    rdata0 = we_r ? {DATA_W{1'b0}} : dataFromMemory;
                end
            end
            default: begin
                ack0 = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small synchronous memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] address, dataToMemory, dataFromMemory;
    logic        writeEnable;

    int checks = 0;
    int failures = 0;

    mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req0           (req0),
        .we0            (we0),
        .addr0          (addr0),
        .wdata0         (wdata0),
        .ack0           (ack0),
        .rdata0         (rdata0),
        .req1           (req1),
        .we1            (we1),
        .addr1          (addr1),
        .wdata1         (wdata1),
        .ack1           (ack1),
        .rdata1         (rdata1),
        .address        (address),
        .dataToMemory   (dataToMemory),
        .writeEnable    (writeEnable),
        .dataFromMemory (dataFromMemory)
    );

    always #5 clk = ~clk;

    // Memory model: unwritten locations read as addr ^ 16'hBEAF
    // (so 16'h0040 reads 16'hBEEF); read data appears the cycle after the address.
    logic [15:0] mem [int];
    always @(posedge clk) begin
        dataFromMemory <= mem.exists(int'(address)) ? mem[int'(address)] : (address ^ 16'hBEAF);
        if (writeEnable) mem[int'(address)] = dataToMemory;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem_idle(input string tag);
        check_eq({tag, "_we"},   {31'd0, writeEnable}, 32'd0);
        check_eq({tag, "_addr"}, {16'd0, address},     32'd0);
        check_eq({tag, "_dtm"},  {16'd0, dataToMemory}, 32'd0);
    endtask

    // Read through port 0 with a bounded wait for the ack.
    task automatic read0(input logic [15:0] a, input logic [15:0] exp, input string tag);
        logic got;
        got  = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = a;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            if (ack0) begin
                got = 1'b1;
                check_eq(tag, {16'd0, rdata0}, {16'd0, exp});
            end
        end
        req0 = 1'b0;
        check_eq({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
        tick();
    endtask

    initial begin
        logic exp_a0, exp_a1;
        reset = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040; wdata0 = 16'h0000;
        req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0000; wdata1 = 16'h0000;

        // Reset held two cycles with req0 high: everything stays 0.
        tick();
        check_mem_idle("rst1");
        check_eq("rst1_ack", {30'd0, ack1, ack0}, 32'd0);
        tick();
        check_mem_idle("rst2");
        check_eq("rst2_ack", {30'd0, ack1, ack0}, 32'd0);
        check_eq("rst2_rdata", {rdata1, rdata0}, 32'd0);
        reset = 1'b0;

        // Single read on port 0.
        tick();
        check_eq("rd_issue_addr", {16'd0, address}, 32'h0040);
        check_eq("rd_issue_we", {31'd0, writeEnable}, 32'd0);
        check_eq("rd_issue_noack", {30'd0, ack1, ack0}, 32'd0);
        tick();
        check_eq("rd_ack0", {31'd0, ack0}, 32'd1);
        check_eq("rd_rdata0", {16'd0, rdata0}, 32'hBEEF);
        check_eq("rd_ack1", {31'd0, ack1}, 32'd0);
        check_mem_idle("rd_resp");
        req0 = 1'b0;
        tick();
        check_eq("rd_after_ack0", {31'd0, ack0}, 32'd0);
        check_eq("rd_after_rdata0", {16'd0, rdata0}, 32'd0);

        // Single write on port 1.
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h1234; wdata1 = 16'hA5A5;
        tick();
        check_eq("wr_issue_we", {31'd0, writeEnable}, 32'd1);
        check_eq("wr_issue_addr", {16'd0, address}, 32'h1234);
        check_eq("wr_issue_dtm", {16'd0, dataToMemory}, 32'hA5A5);
        check_eq("wr_issue_noack", {31'd0, ack1}, 32'd0);
        req1 = 1'b0;
        tick();
        check_eq("wr_ack1", {31'd0, ack1}, 32'd1);
        check_eq("wr_rdata1", {16'd0, rdata1}, 32'd0);
        check_eq("wr_ack0", {31'd0, ack0}, 32'd0);
        check_eq("wr_we_one_cycle", {31'd0, writeEnable}, 32'd0);
        tick();
        read0(16'h1234, 16'hA5A5, "wr_readback");

        // Contention from reset: 0,1,0,1,... one ack every two cycles.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0100;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0200;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_a0 = (k % 4 == 2);
            exp_a1 = (k % 4 == 0);
            check_eq($sformatf("cont_ack0_c%0d", k), {31'd0, ack0}, {31'd0, exp_a0});
            check_eq($sformatf("cont_ack1_c%0d", k), {31'd0, ack1}, {31'd0, exp_a1});
            if (exp_a0) check_eq($sformatf("cont_rdata0_c%0d", k), {16'd0, rdata0}, 32'h0100 ^ 32'hBEAF);
            if (exp_a1) check_eq($sformatf("cont_rdata1_c%0d", k), {16'd0, rdata1}, 32'h0200 ^ 32'hBEAF);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check_eq("cont_end_idle", {30'd0, ack1, ack0}, 32'd0);
        check_mem_idle("cont_end");

        // Single-port streaming: acks three cycles apart, latched address holds.
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0300;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_a0 = (k == 2 || k == 5 || k == 8);
            check_eq($sformatf("strm_ack0_c%0d", k), {31'd0, ack0}, {31'd0, exp_a0});
            if (k == 1) begin
                check_eq("strm_issue0_addr", {16'd0, address}, 32'h0300);
                addr0 = 16'h0555;
            end
            if (k == 2) begin
                check_eq("strm_latched_rdata", {16'd0, rdata0}, 32'h0300 ^ 32'hBEAF);
                addr0 = 16'h0301;
            end
            if (k == 3) check_mem_idle("strm_gap_idle");
            if (k == 4) check_eq("strm_issue1_addr", {16'd0, address}, 32'h0301);
            if (k == 5) begin
                check_eq("strm_rdata1", {16'd0, rdata0}, 32'h0301 ^ 32'hBEAF);
                addr0 = 16'h0302;
            end
            if (k == 7) check_eq("strm_issue2_addr", {16'd0, address}, 32'h0302);
            if (k == 8) check_eq("strm_rdata2", {16'd0, rdata0}, 32'h0302 ^ 32'hBEAF);
        end
        req0 = 1'b0;
        tick();

        // Reset during the ISSUE cycle of a port 1 write.
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0777; wdata1 = 16'h5A5A;
        tick();
        check_eq("rstw_issue_we", {31'd0, writeEnable}, 32'd1);
        reset = 1'b1; req1 = 1'b0;
        tick();
        check_eq("rstw_no_ack1", {31'd0, ack1}, 32'd0);
        check_mem_idle("rstw_after");
        reset = 1'b0;
        tick();
        check_eq("rstw_idle_ack", {30'd0, ack1, ack0}, 32'd0);
        check_mem_idle("rstw_idle");
        read0(16'h0777, 16'h5A5A, "rstw_committed");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
